// File: rtl/bus_cmd_pkg.sv
// bus_cmd_pkg: shared types and parameter defaults for the bus command master
package bus_cmd_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;
endpackage

// File: rtl/bus_cmd_fifo.sv
// bus_cmd_fifo: power-of-two circular command buffer with show-ahead read port
module bus_cmd_fifo
  import bus_cmd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_ptr_q];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/bus_cmd_master.sv
// bus_cmd_master: queues commands and issues them one at a time on a simple bus with timeout
module bus_cmd_master
  import bus_cmd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        m_valid,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_write,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  cmd_t push_cmd, head;
  logic full, empty, pop, done, timed_out;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cur_write_q, cur_write_d;
  logic m_valid_q, m_valid_d, m_write_q, m_write_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [3:0] m_wstrb_q, m_wstrb_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  assign push_cmd = {cmd_write, cmd_addr, cmd_wdata, cmd_wstrb};
  assign cmd_ready = !rst && !full;
  assign busy = !rst && (!empty || state_q != IDLE);
  assign {m_valid, m_write, m_addr, m_wdata, m_wstrb} = {m_valid_q, m_write_q, m_addr_q, m_wdata_q, m_wstrb_q};
  assign {rsp_valid, rsp_rdata, rsp_err, rsp_write} = {rsp_valid_q, rsp_rdata_q, rsp_err_q, rsp_write_q};
  bus_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
    .clk(clk), .rst(rst), .push(cmd_valid && cmd_ready), .din(push_cmd),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  assign done = cur_write_q ? m_ready : m_rvalid;
  assign timed_out = cnt_q == CW'(TIMEOUT);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cur_write_d = cur_write_q;
    m_valid_d = 1'b0;
    m_write_d = 1'b0;
    m_wstrb_d = 4'h0;
    m_addr_d = m_addr_q;
    m_wdata_d = m_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d = rsp_err_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    pop = 1'b0;
    // completion is checked before the timeout so a late completion still wins
    if (state_q == REQ || state_q == WAIT) begin
      if (done || (state_q == WAIT && timed_out)) begin
        state_d = RESP;
        cnt_d = '0;
        rsp_valid_d = 1'b1;
        rsp_write_d = cur_write_q;
        rsp_err_d = !done;
        rsp_rdata_d = (done && !cur_write_q) ? m_rdata : 32'h0;
      end else begin
        state_d = WAIT;
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
      {rsp_valid_d, rsp_err_d, rsp_write_d, rsp_rdata_d} = '0;
    end
    if (!empty && (state_q == IDLE || (state_q == RESP && rsp_ready))) begin
      pop = 1'b1;
      state_d = REQ;
      cur_write_d = head.write;
      m_valid_d = 1'b1;
      m_write_d = head.write;
      m_addr_d = head.addr;
      m_wdata_d = head.wdata;
      m_wstrb_d = head.write ? head.wstrb : 4'h0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cur_write_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cur_write_q <= cur_write_d;
      m_valid_q <= m_valid_d;
      m_write_q <= m_write_d;
      m_addr_q <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_bus_cmd_master.sv
// tb_bus_cmd_master: transaction-level model plus scripted slave checking bus_cmd_master every cycle
module tb_bus_cmd_master;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0] cmd_wstrb = 0;
  logic m_ready = 0, m_rvalid = 0, rsp_ready = 1;
  logic [31:0] m_rdata = 0;
  logic cmd_ready, m_valid, m_write, rsp_valid, rsp_err, rsp_write, busy;
  logic [31:0] m_addr, m_wdata, rsp_rdata;
  logic [3:0] m_wstrb;
  int cmd_lat = 0;
  logic [31:0] cmd_rd = 0;
  int checks = 0, failures = 0;

  bus_cmd_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .m_valid(m_valid),
    .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_write(rsp_write), .busy(busy)
  );

  always #5 clk = ~clk;

  // lat: cycles after m_valid at which the slave completes; <0 means never
  typedef struct packed {
    logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s; int lat; logic [31:0] rd; int acc;
  } cmd_m_t;
  typedef struct packed {
    logic [31:0] a; logic [31:0] rdata; logic err; logic w; int idly; int rdly;
  } obs_t;
  cmd_m_t fq[$];
  obs_t obs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  cmd_m_t cur;
  int cyc = 0, issue_cyc = 0, due = 0, rsp_first = 0;
  bit have_out = 0, exp_issue = 0, rst_prev = 0, exp_err = 0, rsp_prev = 0, rsp_exp, hit, hs;
  logic [31:0] exp_rd;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        if (rst_prev) begin
          chk("rst_m_ctl", {m_valid, m_write, m_wstrb}, 0);
          chk("rst_m_addr", m_addr, 0);
          chk("rst_m_wdata", m_wdata, 0);
          chk("rst_rsp_ctl", {rsp_valid, rsp_err, rsp_write}, 0);
          chk("rst_rsp_rdata", rsp_rdata, 0);
        end
        fq.delete();
        have_out = 0; exp_issue = 0; rsp_prev = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = 0;
        rst_prev = 1;
      end else begin
        rst_prev = 0;
        chk("m_valid", m_valid, exp_issue);
        if (exp_issue && fq.size() > 0) begin
          cur = fq.pop_front();
          have_out = 1;
          issue_cyc = cyc;
          exp_err = cur.lat < 0 || cur.lat > TIMEOUT;
          due = cyc + (exp_err ? TIMEOUT : cur.lat) + 1;
          exp_rd = (cur.w || exp_err) ? 32'h0 : cur.rd;
          chk("m_addr", m_addr, cur.a);
          chk("m_wdata", m_wdata, cur.d);
          chk("m_write_wstrb", {m_write, m_wstrb}, {cur.w, cur.w ? cur.s : 4'h0});
        end else chk("m_idle_ctl", {m_write, m_wstrb}, 0);
        rsp_exp = have_out && cyc >= due;
        chk("rsp_valid", rsp_valid, rsp_exp);
        if (rsp_exp) begin
          chk("rsp_err", rsp_err, exp_err);
          chk("rsp_write", rsp_write, cur.w);
          chk("rsp_rdata", rsp_rdata, exp_rd);
        end
        chk("cmd_ready", cmd_ready, fq.size() < DEPTH);
        chk("busy", busy, fq.size() > 0 || have_out);
        if (rsp_valid && !rsp_prev) rsp_first = cyc;
        rsp_prev = rsp_valid;
        // while waiting, the wrong-type completion is held high to prove it is ignored
        if (have_out && cyc < due) begin
          hit = (cyc - issue_cyc) == cur.lat;
          m_ready = cur.w ? hit : 1'b1;
          m_rvalid = cur.w ? 1'b1 : hit;
          m_rdata = hit ? cur.rd : 32'hDEAD_0000 ^ cyc;
        end else begin
          m_ready = cyc[0];
          m_rvalid = cyc[1];
          m_rdata = 32'hBAD0_0000 | cyc;
        end
        hs = rsp_exp && rsp_ready;
        if (hs) begin
          obs.push_back('{cur.a, rsp_rdata, rsp_err, rsp_write, issue_cyc - cur.acc, rsp_first - issue_cyc});
          have_out = 0;
        end
        exp_issue = fq.size() > 0 && !have_out;
        if (cmd_valid && fq.size() < DEPTH)
          fq.push_back('{cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_lat, cmd_rd, cyc});
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int lat, input logic [31:0] rd);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    cmd_lat = lat; cmd_rd = rd;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = cmd_ready;
      n++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 0;
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_obs(input int n);
    int k;
    k = 0;
    while (obs.size() < n && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_rsp", obs.size() >= n, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    send(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
    wait_obs(1);
    chk("wr_rdata", obs[0].rdata, 0);
    chk("wr_err", obs[0].err, 0);
    chk("wr_write", obs[0].w, 1);
    chk("wr_issue_dly", obs[0].idly, 2);
    chk("wr_rsp_dly", obs[0].rdly, 1);
    send(0, 32'h2000_0000, 32'h0, 4'hF, 2, 32'hA5A5_0001);
    wait_obs(2);
    chk("rd_rdata", obs[1].rdata, 32'hA5A5_0001);
    chk("rd_err", obs[1].err, 0);
    chk("rd_rsp_dly", obs[1].rdly, 3);
    send(0, 32'h2000_0010, 32'h0, 4'h0, -1, 32'h0);
    send(1, 32'h3000_0000, 32'h1111_2222, 4'h3, 1, 0);
    wait_obs(4);
    chk("to_err", obs[2].err, 1);
    chk("to_rdata", obs[2].rdata, 0);
    chk("to_rsp_dly", obs[2].rdly, 17);
    chk("after_to_addr", obs[3].a, 32'h3000_0000);
    chk("after_to_err", obs[3].err, 0);
    send(0, 32'h2000_0020, 32'h0, 4'h0, 16, 32'h1234_5678);
    send(1, 32'h3000_0010, 32'h5555_AAAA, 4'hC, 16, 0);
    wait_obs(6);
    chk("late_rd_err", obs[4].err, 0);
    chk("late_rd_rdata", obs[4].rdata, 32'h1234_5678);
    chk("late_wr_err", obs[5].err, 0);
    chk("late_wr_rsp_dly", obs[5].rdly, 17);
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) send(1, 32'h5000_0000 + i * 4, i, 4'hF, 0, 0);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("held_rsp_count", obs.size(), 6);
    rsp_ready = 1;
    wait_obs(11);
    for (int i = 0; i < 5; i++) begin
      chk("order_addr", obs[6 + i].a, 32'h5000_0000 + i * 4);
      chk("order_err", obs[6 + i].err, 0);
    end
    send(0, 32'h6000_0000, 32'h0, 4'h0, -1, 32'h0);
    send(1, 32'h6000_0004, 32'h7, 4'hF, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_rsp", obs.size(), 11);
    chk("rst_idle_busy", busy, 0);
    send(1, 32'h7000_0000, 32'hCAFE_F00D, 4'h5, 3, 0);
    wait_obs(12);
    chk("post_rst_addr", obs[11].a, 32'h7000_0000);
    chk("post_rst_err", obs[11].err, 0);
    chk("post_rst_write", obs[11].w, 1);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/bus_cmd_master.md
BUS_CMD_MASTER -- requirements
Module: bus_cmd_master

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 16, maximum cycles spent waiting for a completion before an error response is raised.
REQ-003 clk  in  1  single clock; all logic rises on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer occurs when both are 1.
REQ-006 cmd_write  in  1  1=write, 0=read.
REQ-007 cmd_addr / cmd_wdata  in  32 / 32  byte address and write data.
REQ-008 cmd_wstrb  in  4  byte enables (write only).
REQ-009 m_valid, m_write  out  1 each  bus request to the interconnect.
REQ-010 m_addr, m_wdata  out  32 each  bus address and write data.
REQ-011 m_wstrb  out  4  bus byte enables.
REQ-012 m_ready  in  1  write completion.
REQ-013 m_rvalid  in  1  read data valid.
REQ-014 m_rdata  in  32  read data.
REQ-015 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-016 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-017 rsp_err, rsp_write  out  1 each  timeout flag and echo of the command type.
REQ-018 busy  out  1  1 when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-019 The block SHALL buffer commands in a DEPTH-entry FIFO; cmd_ready = !full.
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT, RESP.
REQ-021 IDLE -> REQ when the FIFO is non-empty: pop one entry and register it as the current command.
REQ-022 In REQ, m_valid SHALL be 1 for exactly one cycle, with m_addr and m_wdata from the command, m_write=cmd_write, and m_wstrb=cmd_wstrb for writes or 4'h0 for reads.
REQ-023 A command accepted into an empty FIFO while IDLE at edge T SHALL produce m_valid=1 in the cycle after edge T+1.
REQ-024 Outside REQ, m_valid, m_write and m_wstrb SHALL be 0; m_addr and m_wdata hold their last values.
REQ-025 Completion SHALL be sampled in the REQ cycle and in every WAIT cycle.
REQ-026 Completion condition: write = m_ready==1; read = m_rvalid==1, with m_rdata captured in that same cycle.
REQ-027 REQ -> RESP on completion in the REQ cycle; otherwise REQ -> WAIT.
REQ-028 A WAIT counter SHALL start at 1 on entry to WAIT and increment each cycle.
REQ-029 On completion in WAIT, go to RESP with rsp_err=0.
REQ-030 If the counter reaches TIMEOUT without completion, go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-031 Completion and timeout in the same cycle: completion SHALL win.
REQ-032 In RESP, rsp_valid=1 and all rsp_* outputs SHALL stay stable until rsp_ready=1.
REQ-033 On the rsp_ready edge: go to IDLE, or pop directly into REQ if the FIFO is non-empty (no idle bubble).
REQ-034 m_ready / m_rvalid pulses in IDLE or RESP SHALL be ignored.
REQ-035 Simultaneous FIFO push and pop SHALL be legal at any occupancy; the count SHALL be unchanged when both happen.
REQ-036 Pointers SHALL wrap modulo DEPTH.
REQ-037 Commands SHALL be issued strictly in order, with at most one outstanding.

Reset
REQ-038 While rst=1: FSM=IDLE; FIFO empty; counter=0; m_valid=m_write=0; m_addr=m_wdata=0; m_wstrb=0; rsp_valid=rsp_err=rsp_write=0; rsp_rdata=0; busy=0; cmd_ready=0.
REQ-039 cmd_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-040 Reset asserted mid-transaction SHALL discard the in-flight command, all queued commands and any pending response; no response is emitted.

Structure
REQ-041 Package bus_cmd_pkg SHALL hold the command struct typedef (write, addr, wdata, wstrb), the FSM state enum, and defaults for DEPTH and TIMEOUT.
REQ-042 The FIFO SHALL be a separate sub-module, bus_cmd_fifo, parameterised by DEPTH and element type width.

Verification
REQ-043 Write addr=0x1000_0004, data=0xDEADBEEF, wstrb=0xF, m_ready=1 in the REQ cycle -> one m_valid pulse; rsp_valid with err=0, write=1, rdata=0.
REQ-044 Read addr=0x2000_0000, slave returns m_rvalid=1 two cycles after m_valid with rdata=0xA5A5_0001 -> rsp_rdata=0xA5A5_0001, err=0.
REQ-045 Read with the slave never responding, TIMEOUT=16 -> rsp_err=1 and rdata=0 on the 16th WAIT cycle; the next queued command then issues.
REQ-046 Push 5 commands back-to-back with rsp_ready=0 (DEPTH=4) -> cmd_ready drops after 4 commands are buffered plus 1 in flight; all 5 responses arrive in order once rsp_ready=1.
REQ-047 Assert rst during WAIT of a read -> all outputs at reset values the next cycle, no response; a new command then completes normally.
REQ-048 m_ready=1 on the same cycle the counter reaches TIMEOUT -> rsp_err=0.
